// File: rtl/memory_bus_serializer.sv
// Serializes a 32-bit CPU data-memory access onto an 8-bit pad bus, LSB-first, with a ready/valid stall.
// Optional MEMORY_BUS_SIZE_EN adds request_size to shorten the data phase to 1, 2 or 4 bytes.
module memory_bus_serializer #(
    parameter int ADDRESS_BYTES = 2,
    parameter int WAIT_CYCLES   = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        request_valid,
    output logic        request_ready,
    input  logic        request_write,
    input  logic [31:0] request_address,
    input  logic [31:0] request_write_data,
`ifdef MEMORY_BUS_SIZE_EN
    input  logic [1:0]  request_size,
`endif
    output logic        response_valid,
    output logic [31:0] response_read_data,
    output logic [7:0]  bus_address,
    output logic        bus_strobe,
    output logic        bus_write,
    output logic [7:0]  bus_data_out,
    output logic [7:0]  bus_data_oe,
    input  logic [7:0]  bus_data_in
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ADDRESS = 3'd1,
        WAIT    = 3'd2,
        WRITE   = 3'd3,
        READ    = 3'd4,
        DONE    = 3'd5
    } state_t;

    localparam int WAIT_LAST_INT = (WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0;
    localparam logic [2:0] ADDR_LAST = 3'(ADDRESS_BYTES - 1);
    localparam logic [2:0] WAIT_LAST = 3'(WAIT_LAST_INT);

    state_t      state_reg;
    logic [2:0]  count_reg;
    logic        write_reg;
    logic [31:0] addr_reg;
    logic [31:0] wdata_reg;
    logic [31:0] asm_reg;
    logic [31:0] read_assembled;
    logic [2:0]  data_last;

`ifdef MEMORY_BUS_SIZE_EN
    logic [2:0]  data_last_reg;
    assign data_last = data_last_reg;
`else
    assign data_last = 3'd3;
`endif

    assign request_ready = (state_reg == IDLE);

    // Lane k of the assembly register takes the bus byte when the counter points at it.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign read_assembled[8*gi +: 8] = (count_reg[1:0] == 2'(gi)) ? bus_data_in
                                                                          : asm_reg[8*gi +: 8];
        end
    endgenerate

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg          <= IDLE;
            count_reg          <= '0;
            write_reg          <= 1'b0;
            addr_reg           <= '0;
            wdata_reg          <= '0;
            asm_reg            <= '0;
            response_valid     <= 1'b0;
            response_read_data <= '0;
            bus_address        <= '0;
            bus_strobe         <= 1'b0;
            bus_write          <= 1'b0;
            bus_data_out       <= '0;
            bus_data_oe        <= '0;
`ifdef MEMORY_BUS_SIZE_EN
            data_last_reg      <= 3'd3;
`endif
        end else begin
            // Bus outputs are registered: each branch loads the values for the next cycle.
            response_valid <= 1'b0;
            bus_address    <= '0;
            bus_strobe     <= 1'b0;
            bus_data_out   <= '0;
            bus_data_oe    <= '0;
            case (state_reg)
                IDLE: begin
                    bus_write <= 1'b0;
                    if (request_valid) begin
                        state_reg   <= ADDRESS;
                        count_reg   <= '0;
                        write_reg   <= request_write;
                        addr_reg    <= request_address >> 8;
                        wdata_reg   <= request_write_data;
                        asm_reg     <= '0;
                        bus_address <= request_address[7:0];
                        bus_strobe  <= 1'b1;
                        bus_write   <= request_write;
`ifdef MEMORY_BUS_SIZE_EN
                        case (request_size)
                            2'd0:    data_last_reg <= 3'd0;
                            2'd1:    data_last_reg <= 3'd1;
                            default: data_last_reg <= 3'd3;
                        endcase
`endif
                    end
                end
                ADDRESS: begin
                    if (count_reg == ADDR_LAST) begin
                        count_reg <= '0;
                        if (write_reg) begin
                            state_reg    <= WRITE;
                            bus_data_out <= wdata_reg[7:0];
                            bus_data_oe  <= 8'hFF;
                            wdata_reg    <= wdata_reg >> 8;
                        end else if (WAIT_CYCLES > 0) begin
                            state_reg <= WAIT;
                        end else begin
                            state_reg <= READ;
                        end
                    end else begin
                        count_reg   <= count_reg + 3'd1;
                        bus_address <= addr_reg[7:0];
                        bus_strobe  <= 1'b1;
                        addr_reg    <= addr_reg >> 8;
                    end
                end
                WAIT: begin
                    if (count_reg == WAIT_LAST) begin
                        count_reg <= '0;
                        state_reg <= READ;
                    end else begin
                        count_reg <= count_reg + 3'd1;
                    end
                end
                WRITE: begin
                    if (count_reg == data_last) begin
                        state_reg      <= DONE;
                        response_valid <= 1'b1;
                        bus_write      <= 1'b0;
                    end else begin
                        count_reg    <= count_reg + 3'd1;
                        bus_data_out <= wdata_reg[7:0];
                        bus_data_oe  <= 8'hFF;
                        wdata_reg    <= wdata_reg >> 8;
                    end
                end
                READ: begin
                    asm_reg <= read_assembled;
                    if (count_reg == data_last) begin
                        state_reg          <= DONE;
                        response_valid     <= 1'b1;
                        response_read_data <= read_assembled;
                        bus_write          <= 1'b0;
                    end else begin
                        count_reg <= count_reg + 3'd1;
                    end
                end
                DONE: begin
                    state_reg <= IDLE;
                    bus_write <= 1'b0;
                end
                default: begin
                    state_reg <= IDLE;
                    bus_write <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_memory_bus_serializer.sv
// Bench for memory_bus_serializer: table vectors, reset/abort and back-to-back sequences, random accesses vs a cycle model.
module tb_memory_bus_serializer;

    localparam int AB = 2;
    localparam int W  = 1;
`ifdef MEMORY_BUS_SIZE_EN
    localparam bit SIZE_EN = 1'b1;
`else
    localparam bit SIZE_EN = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset;
    logic        request_valid;
    logic        request_ready;
    logic        request_write;
    logic [31:0] request_address;
    logic [31:0] request_write_data;
`ifdef MEMORY_BUS_SIZE_EN
    logic [1:0]  request_size;
`endif
    logic        response_valid;
    logic [31:0] response_read_data;
    logic [7:0]  bus_address;
    logic        bus_strobe;
    logic        bus_write;
    logic [7:0]  bus_data_out;
    logic [7:0]  bus_data_oe;
    logic [7:0]  bus_data_in;

    int checks = 0;
    int errors = 0;
    logic [31:0] model_read = 32'h0;

    memory_bus_serializer #(.ADDRESS_BYTES(AB), .WAIT_CYCLES(W)) dut (
        .clock              (clock),
        .reset              (reset),
        .request_valid      (request_valid),
        .request_ready      (request_ready),
        .request_write      (request_write),
        .request_address    (request_address),
        .request_write_data (request_write_data),
`ifdef MEMORY_BUS_SIZE_EN
        .request_size       (request_size),
`endif
        .response_valid     (response_valid),
        .response_read_data (response_read_data),
        .bus_address        (bus_address),
        .bus_strobe         (bus_strobe),
        .bus_write          (bus_write),
        .bus_data_out       (bus_data_out),
        .bus_data_oe        (bus_data_oe),
        .bus_data_in        (bus_data_in)
    );

    always #5 clock = ~clock;

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rbytes;
        logic [1:0]  size;
        bit          hold;
        logic [31:0] exp_rdata;
        int          exp_lat;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic int data_len(input logic [1:0] size);
        if (SIZE_EN && size == 2'd0) return 1;
        if (SIZE_EN && size == 2'd1) return 2;
        return 4;
    endfunction

    function automatic logic [31:0] len_mask(input int n);
        if (n >= 4) return 32'hFFFF_FFFF;
        return (32'h1 << (8 * n)) - 32'h1;
    endfunction

    // Starts in an IDLE cycle (at a falling edge); ends at the falling edge of the following IDLE cycle.
    task automatic run_access(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [31:0] rbytes, input logic [1:0] size, input bit hold,
                              input int abort_at, output int lat_seen, output logic [31:0] rdata_seen);
        int n;
        int total;
        logic [26:0] exp_vec;
        logic [26:0] act_vec;
        logic        e_strobe, e_wr, e_rv;
        logic [7:0]  e_addr, e_dout, e_oe;
        logic [31:0] exp_rd;
        n = data_len(size);
        total = AB + (wr ? 0 : W) + n + 1;
        lat_seen = 0;
        rdata_seen = 32'h0;
        check("ready_idle", {31'h0, request_ready}, 32'h1);
        request_valid      = 1'b1;
        request_write      = wr;
        request_address    = addr;
        request_write_data = wdata;
`ifdef MEMORY_BUS_SIZE_EN
        request_size       = size;
`endif
        @(posedge clock);
        for (int k = 1; k <= total; k++) begin
            @(negedge clock);
            // Garbage on the request side while busy must be ignored.
            request_valid      = hold;
            request_write      = 1'($urandom);
            request_address    = $urandom;
            request_write_data = $urandom;
`ifdef MEMORY_BUS_SIZE_EN
            request_size       = 2'($urandom);
`endif
            if (!wr && k > AB + W && k <= AB + W + n)
                bus_data_in = 8'(rbytes >> (8 * (k - AB - W - 1)));
            else
                bus_data_in = 8'($urandom);
            e_strobe = 1'b0; e_wr = 1'b0; e_rv = 1'b0;
            e_addr = 8'h00; e_dout = 8'h00; e_oe = 8'h00;
            if (k <= AB) begin
                e_strobe = 1'b1;
                e_addr   = 8'(addr >> (8 * (k - 1)));
                e_wr     = wr;
            end else if (k == total) begin
                e_rv = 1'b1;
            end else if (wr) begin
                e_wr   = 1'b1;
                e_dout = 8'(wdata >> (8 * (k - AB - 1)));
                e_oe   = 8'hFF;
            end
            exp_vec = {e_strobe, e_addr, e_wr, e_dout, e_oe, e_rv};
            act_vec = {bus_strobe, bus_address, bus_write, bus_data_out, bus_data_oe, response_valid};
            check($sformatf("bus_cycle%0d", k), {5'h0, act_vec}, {5'h0, exp_vec});
            check("ready_busy", {31'h0, request_ready}, 32'h0);
            if (response_valid) begin
                lat_seen   = k;
                rdata_seen = response_read_data;
            end
            if (k == total) begin
                exp_rd = wr ? model_read : (rbytes & len_mask(n));
                check("read_data", response_read_data, exp_rd);
                model_read = exp_rd;
            end
            if (k == abort_at) begin
                reset = 1'b1;
                request_valid = 1'b0;
                @(negedge clock);
                reset = 1'b0;
                model_read = 32'h0;
                check("abort_ready", {31'h0, request_ready}, 32'h1);
                check("abort_rv", {31'h0, response_valid}, 32'h0);
                check("abort_rdata", response_read_data, 32'h0);
                check("abort_bus", {15'h0, bus_strobe, bus_data_oe, bus_address}, 32'h0);
                @(negedge clock);
                check("abort_rv2", {31'h0, response_valid}, 32'h0);
                $display("access abort wr=%0d addr=%h at cycle %0d", wr, addr, k);
                return;
            end
        end
        @(negedge clock);
        if (!hold) request_valid = 1'b0;
        $display("access wr=%0d addr=%h wdata=%h size=%0d lat=%0d rdata=%h",
                 wr, addr, wdata, size, lat_seen, rdata_seen);
    endtask

    vec_t        vecs[5];
    int          lat;
    logic [31:0] rd;

    initial begin
        reset = 1'b1;
        request_valid = 1'b0;
        request_write = 1'b0;
        request_address = '0;
        request_write_data = '0;
`ifdef MEMORY_BUS_SIZE_EN
        request_size = 2'd3;
`endif
        bus_data_in = 8'h00;
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        check("rst_ready", {31'h0, request_ready}, 32'h1);
        check("rst_rv", {31'h0, response_valid}, 32'h0);
        check("rst_oe", {24'h0, bus_data_oe}, 32'h0);
        check("rst_addr", {24'h0, bus_address}, 32'h0);
        check("rst_strobe", {31'h0, bus_strobe}, 32'h0);

        vecs[0] = '{1'b1, 32'h0000_1234, 32'hDEAD_BEEF, 32'h0,         2'd3, 1'b0, 32'h0000_0000, 7};
        vecs[1] = '{1'b0, 32'h0000_0056, 32'h0,         32'h4433_2211, 2'd3, 1'b0, 32'h4433_2211, 8};
        vecs[2] = '{1'b0, 32'h0000_ABCD, 32'h0,         32'h8899_AABB, 2'd3, 1'b1, 32'h8899_AABB, 8};
        vecs[3] = '{1'b0, 32'h0000_0001, 32'h0,         32'h00FF_00FF, 2'd2, 1'b0, 32'h00FF_00FF, 8};
        vecs[4] = '{1'b1, 32'hFFFF_FFFF, 32'h0102_0304, 32'h0,         2'd3, 1'b0, 32'h00FF_00FF, 7};
        for (int i = 0; i < 5; i++) begin
            run_access(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].rbytes, vecs[i].size,
                       vecs[i].hold, 0, lat, rd);
            check($sformatf("vec%0d_latency", i), lat, vecs[i].exp_lat);
            check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
        end

        // Reset during the second READ cycle of a load.
        run_access(1'b0, 32'h0000_0056, 32'h0, 32'h4433_2211, 2'd3, 1'b0, AB + W + 2, lat, rd);

`ifdef MEMORY_BUS_SIZE_EN
        run_access(1'b0, 32'h0000_0056, 32'h0, 32'hFFFF_FFAB, 2'd0, 1'b0, 0, lat, rd);
        check("byte_latency", lat, 5);
        check("byte_rdata", rd, 32'h0000_00AB);
        run_access(1'b0, 32'h0000_0056, 32'h0, 32'h4433_2211, 2'd2, 1'b0, 0, lat, rd);
        check("word_rdata", rd, 32'h4433_2211);
`endif

        for (int i = 0; i < 40; i++) begin
            run_access(1'($urandom), $urandom, $urandom, $urandom, 2'($urandom),
                       (i != 39) ? 1'($urandom) : 1'b0, 0, lat, rd);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
